// File: rtl/b08_pkg.sv
// Shared types and constants for the b08 stimulus driver.
// Holds the FSM state type, strobe length and the LFSR/MISR tap masks.
package b08_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam int          START_HIGH = 2;
  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
  localparam logic [15:0] MISR_TAPS  = 16'hB400;

  // One MISR step: shift left with tap feedback, then fold in the 4-bit result.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [3:0] o);
    misr_step = {sig[14:0], ^(sig & MISR_TAPS)} ^ {12'h000, o};
  endfunction

endpackage

// File: rtl/b08_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
// The seed is forced non-zero so the register can never lock up at all-zeros.
module b08_lfsr8
  import b08_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  output logic [7:0] next_word
);

  localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] q;

  // The upcoming value is exported so the driver can register it on the same edge.
  always_comb begin
    next_word = q;
    if (load) begin
      next_word = SEED_SAFE;
    end else if (enable) begin
      next_word = {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= SEED_SAFE;
    end else begin
      q <= next_word;
    end
  end

endmodule

// File: rtl/b08_driver.sv
// Stimulus engine for the b08 matcher: strobes LFSR words into it, samples
// the 4-bit result after a settle window and compresses results into a MISR.
module b08_driver
  import b08_pkg::*;
#(
  parameter int         NUM_VECTORS = 16,
  parameter int         WAIT_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        abort,
  output logic        START,
  output logic        I_7_,
  output logic        I_6_,
  output logic        I_5_,
  output logic        I_4_,
  output logic        I_3_,
  output logic        I_2_,
  output logic        I_1_,
  output logic        I_0_,
  input  logic        O_REG_3_,
  input  logic        O_REG_2_,
  input  logic        O_REG_1_,
  input  logic        O_REG_0_,
  output logic [3:0]  result,
  output logic        result_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;
  logic [8:0]  vec_idx;
  logic [7:0]  word;
  logic [7:0]  next_word;
  logic [3:0]  o_in;
  logic        start_run;
  logic        capture;
  logic        load_word;

  assign o_in = {O_REG_3_, O_REG_2_, O_REG_1_, O_REG_0_};
  assign {I_7_, I_6_, I_5_, I_4_, I_3_, I_2_, I_1_, I_0_} = word;

  // Abort overrides every transition, including a run request seen in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = STROBE;
      STROBE:  if (cnt == 16'(START_HIGH - 1)) next_state = WAIT;
      WAIT:    if (cnt == 16'(WAIT_CYCLES - 1)) next_state = CAPTURE;
      CAPTURE: next_state = (vec_idx < 9'(NUM_VECTORS - 1)) ? STROBE : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  assign start_run = (state == IDLE) && (next_state == STROBE);
  assign capture   = (state == CAPTURE) && !abort;
  assign load_word = (state != STROBE) && (next_state == STROBE);

  b08_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .load      (start_run),
    .enable    (capture),
    .next_word (next_word)
  );

  // Outputs are decoded from next_state so they are registered yet cycle-aligned with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      vec_idx      <= 9'd0;
      word         <= 8'h00;
      START        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= 4'h0;
      result_valid <= 1'b0;
      signature    <= 16'h0000;
    end else begin
      state        <= next_state;
      cnt          <= (next_state != state) ? 16'd0 : cnt + 16'd1;
      START        <= (next_state == STROBE);
      busy         <= (next_state != IDLE);
      done         <= (next_state == DONE);
      result_valid <= capture;
      if (load_word) word <= next_word;
      if (start_run) begin
        vec_idx   <= 9'd0;
        signature <= 16'h0000;
      end else if (capture) begin
        vec_idx   <= vec_idx + 9'd1;
        result    <= o_in;
        signature <= misr_step(signature, o_in);
      end
    end
  end

endmodule

// File: tb/tb_b08_driver.sv
// Self-checking bench for b08_driver: random matcher results are fed back and
// compared against a cycle-level reference model of the run timing and MISR.
module tb_b08_driver;

  localparam int         N    = 4;
  localparam int         W    = 12;
  localparam int         P    = W + 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clock;
  logic        reset;
  logic        run;
  logic        abort;
  logic        START;
  logic        I_7_, I_6_, I_5_, I_4_, I_3_, I_2_, I_1_, I_0_;
  logic        O_REG_3_, O_REG_2_, O_REG_1_, O_REG_0_;
  logic [3:0]  result;
  logic        result_valid;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [7:0]  i_word;
  logic [3:0]  o_val;

  int errors = 0;
  int checks = 0;

  assign i_word = {I_7_, I_6_, I_5_, I_4_, I_3_, I_2_, I_1_, I_0_};
  assign {O_REG_3_, O_REG_2_, O_REG_1_, O_REG_0_} = o_val;

  b08_driver #(.NUM_VECTORS(N), .WAIT_CYCLES(W), .LFSR_SEED(SEED)) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .abort        (abort),
    .START        (START),
    .I_7_         (I_7_),
    .I_6_         (I_6_),
    .I_5_         (I_5_),
    .I_4_         (I_4_),
    .I_3_         (I_3_),
    .I_2_         (I_2_),
    .I_1_         (I_1_),
    .I_0_         (I_0_),
    .O_REG_3_     (O_REG_3_),
    .O_REG_2_     (O_REG_2_),
    .O_REG_1_     (O_REG_1_),
    .O_REG_0_     (O_REG_0_),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done),
    .signature    (signature)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] model_lfsr(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [3:0] o);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {12'h000, o};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; abort = 1'b0; o_val = 4'h0;
    repeat (2) tick;
    checks += 7;
    if (START !== 1'b0)          begin errors++; $display("[TB] FAIL reset_start got=%b want=0", START); end
    if (i_word !== 8'h00)        begin errors++; $display("[TB] FAIL reset_word got=%h want=00", i_word); end
    if (result !== 4'h0)         begin errors++; $display("[TB] FAIL reset_result got=%h want=0", result); end
    if (result_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", result_valid); end
    if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0)           begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    if (signature !== 16'h0000)  begin errors++; $display("[TB] FAIL reset_sig got=%h want=0000", signature); end
    reset = 1'b0;
    tick;
  endtask

  // Full run with random results; every output is checked every cycle.
  task automatic test_sequence;
    logic [7:0]  words [N];
    logic [3:0]  ovals [N];
    logic [7:0]  w;
    logic [15:0] exp_sig;
    logic [3:0]  exp_res;
    logic [7:0]  exp_word;
    bit          have_res;
    int          phase, v, k;
    bit          in_run, exp_start, exp_busy, exp_done, exp_valid;
    w = SEED;
    for (int i = 0; i < N; i++) begin
      words[i] = w;
      w = model_lfsr(w);
      ovals[i] = 4'($urandom_range(0, 15));
    end
    exp_sig = 16'h0000; exp_res = 4'h0; have_res = 1'b0;
    run = 1'b1;
    tick;
    run = 1'b0;
    for (int c = 1; c <= N * P + 2; c++) begin
      phase     = (c - 1) % P + 1;
      v         = (c - 1) / P;
      in_run    = (c <= N * P);
      exp_start = in_run && (phase <= 2);
      exp_busy  = (c <= N * P + 1);
      exp_done  = (c == N * P + 1);
      exp_word  = in_run ? words[v] : words[N-1];
      k         = (c - 1) / P;
      exp_valid = (c > 1) && ((c - 1) % P == 0) && (k >= 1) && (k <= N);
      if (exp_valid) begin
        exp_sig  = model_misr(exp_sig, ovals[k-1]);
        exp_res  = ovals[k-1];
        have_res = 1'b1;
      end
      checks += 6;
      if (START !== exp_start)       begin errors++; $display("[TB] FAIL seq_start c=%0d got=%b want=%b", c, START, exp_start); end
      if (busy !== exp_busy)         begin errors++; $display("[TB] FAIL seq_busy c=%0d got=%b want=%b", c, busy, exp_busy); end
      if (done !== exp_done)         begin errors++; $display("[TB] FAIL seq_done c=%0d got=%b want=%b", c, done, exp_done); end
      if (i_word !== exp_word)       begin errors++; $display("[TB] FAIL seq_word c=%0d got=%h want=%h", c, i_word, exp_word); end
      if (result_valid !== exp_valid) begin errors++; $display("[TB] FAIL seq_valid c=%0d got=%b want=%b", c, result_valid, exp_valid); end
      if (signature !== exp_sig)     begin errors++; $display("[TB] FAIL seq_sig c=%0d got=%h want=%h", c, signature, exp_sig); end
      if (have_res) begin
        checks++;
        if (result !== exp_res) begin errors++; $display("[TB] FAIL seq_result c=%0d got=%h want=%h", c, result, exp_res); end
      end
      if (in_run && phase == 1) o_val = ovals[v];
      else if (in_run && phase > 1) o_val = ($urandom_range(0, 3) == 0 && phase < P) ? 4'($urandom_range(0, 15)) : ovals[v];
      tick;
    end
  endtask

  task automatic test_misr;
    logic [15:0] exp_sig;
    o_val = 4'hF;
    run = 1'b1;
    tick;
    run = 1'b0;
    repeat (P) tick;
    checks += 2;
    if (signature !== 16'h000F) begin errors++; $display("[TB] FAIL misr_first got=%h want=000F", signature); end
    if (result !== 4'hF)        begin errors++; $display("[TB] FAIL misr_result got=%h want=F", result); end
    repeat (P) tick;
    checks++;
    if (signature !== 16'h0011) begin errors++; $display("[TB] FAIL misr_second got=%h want=0011", signature); end
    repeat ((N - 2) * P) tick;
    exp_sig = 16'h0000;
    for (int i = 0; i < N; i++) exp_sig = model_misr(exp_sig, 4'hF);
    checks += 2;
    if (done !== 1'b1)         begin errors++; $display("[TB] FAIL misr_done got=%b want=1", done); end
    if (signature !== exp_sig) begin errors++; $display("[TB] FAIL misr_final got=%h want=%h", signature, exp_sig); end
    tick;
    o_val = 4'h0;
    run = 1'b1;
    tick;
    run = 1'b0;
    repeat (N * P) tick;
    checks += 2;
    if (done !== 1'b1)          begin errors++; $display("[TB] FAIL misr_zero_done got=%b want=1", done); end
    if (signature !== 16'h0000) begin errors++; $display("[TB] FAIL misr_zero got=%h want=0000", signature); end
    tick;
  endtask

  task automatic test_abort;
    logic [3:0]  o0;
    logic [15:0] exp_sig;
    bit          saw_done;
    o0 = 4'($urandom_range(1, 15));
    o_val = o0;
    run = 1'b1;
    tick;
    run = 1'b0;
    repeat (P) tick;
    exp_sig = model_misr(16'h0000, o0);
    o_val = ~o0;
    repeat (4) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks += 5;
    if (busy !== 1'b0)         begin errors++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    if (START !== 1'b0)        begin errors++; $display("[TB] FAIL abort_start got=%b want=0", START); end
    if (done !== 1'b0)         begin errors++; $display("[TB] FAIL abort_done got=%b want=0", done); end
    if (signature !== exp_sig) begin errors++; $display("[TB] FAIL abort_sig got=%h want=%h", signature, exp_sig); end
    if (result !== o0)         begin errors++; $display("[TB] FAIL abort_result got=%h want=%h", result, o0); end
    saw_done = 1'b0;
    repeat (P + 5) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("[TB] FAIL abort_stays_idle got=active want=idle"); end
    run = 1'b1; abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_priority got=%b want=0", busy); end
    tick;
    run = 1'b0;
    checks += 3;
    if (START !== 1'b1)         begin errors++; $display("[TB] FAIL abort_restart_start got=%b want=1", START); end
    if (i_word !== SEED)        begin errors++; $display("[TB] FAIL abort_restart_word got=%h want=%h", i_word, SEED); end
    if (signature !== 16'h0000) begin errors++; $display("[TB] FAIL abort_restart_sig got=%h want=0000", signature); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_back_to_back;
    o_val = 4'($urandom_range(0, 15));
    run = 1'b1;
    tick;
    repeat (N * P) tick;
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got=%b want=1", done); end
    tick;
    checks += 2;
    if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL b2b_idle_busy got=%b want=0", busy); end
    if (START !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_start got=%b want=0", START); end
    tick;
    run = 1'b0;
    checks += 3;
    if (START !== 1'b1)         begin errors++; $display("[TB] FAIL b2b_start got=%b want=1", START); end
    if (i_word !== SEED)        begin errors++; $display("[TB] FAIL b2b_word got=%h want=%h", i_word, SEED); end
    if (signature !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_sig got=%h want=0000", signature); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_reset_midrun;
    run = 1'b1;
    tick;
    run = 1'b0;
    checks++;
    if (START !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_start got=%b want=1", START); end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (START !== 1'b0)  begin errors++; $display("[TB] FAIL rst_async_start got=%b want=0", START); end
    if (i_word !== 8'h00) begin errors++; $display("[TB] FAIL rst_async_word got=%h want=00", i_word); end
    if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL rst_async_busy got=%b want=0", busy); end
    if (signature !== 16'h0000) begin errors++; $display("[TB] FAIL rst_async_sig got=%h want=0000", signature); end
    #3 reset = 1'b0;
    repeat (2) tick;
    checks += 2;
    if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL rst_idle_busy got=%b want=0", busy); end
    if (START !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_start got=%b want=0", START); end
    run = 1'b1;
    tick;
    run = 1'b0;
    checks++;
    if (i_word !== SEED) begin errors++; $display("[TB] FAIL rst_restart_word got=%h want=%h", i_word, SEED); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_sequence;
    test_misr;
    test_abort;
    test_back_to_back;
    test_reset_midrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
